ysyx_22041071_wb_commit: RTL

Write-back and commit stage of the ysyx_22041071 five-stage RV64 pipeline, directly downstream of the MEM stage. Accepts one retiring instruction per cycle over the valid6/ready6 handshake and writes its result into the 32×64-bit integer register file, which this block owns. Serves the two decode-stage read ports with same-cycle write-through bypass. Publishes a registered commit record plus retire/cycle counters, and halts the pipeline on `ebreak`.

---
 rtl/ysyx_22041071_wb_commit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ysyx_22041071_wb_commit.sv
`default_nettype none
// ============================================================================
// ysyx_22041071_wb_commit : RV64 write-back/commit stage, owns the 32x64 regfile.
// Optional commit trace and counters: `YSYX_22041071_COMMIT_TRACE_EN. Rev 1.0
// ============================================================================
module ysyx_22041071_wb_commit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid6,
  output logic        ready6,
  input  logic [63:0] PC6,
  input  logic [31:0] Ins5,
  input  logic        reg_w_en4,
  input  logic [4:0]  rdest3,
  input  logic [63:0] WB_data1,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [63:0] rs1_data,
  output logic [63:0] rs2_data,
  output logic        commit_valid,
  output logic [63:0] commit_pc,
  output logic [31:0] commit_ins,
  output logic        commit_wen,
  output logic [4:0]  commit_wdest,
  output logic [63:0] commit_wdata,
  output logic [63:0] instr_cnt,
  output logic [63:0] cycle_cnt,
  output logic        halt,
  output logic [63:0] halt_code
);

  localparam logic [31:0] EBREAK_INS = 32'h0010_0073;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;
  state_t state, state_next;

  logic [63:0] regs [32];
  logic        accept;
  logic        is_ebreak;
  logic        wr_fire;
  logic [63:0] a0_bypass;

  assign ready6    = (state == RUN);
  assign halt      = (state == HALTED);
  assign accept    = valid6 & ready6;
  assign is_ebreak = (Ins5 == EBREAK_INS);
  // ebreak never writes, so its own reg_w_en4 is ignored for write and bypass
  assign wr_fire   = accept & reg_w_en4 & (rdest3 != 5'd0) & ~is_ebreak;

  assign rs1_data  = (rs1_addr == 5'd0) ? 64'h0 :
                     (wr_fire && (rdest3 == rs1_addr)) ? WB_data1 : regs[rs1_addr];
  assign rs2_data  = (rs2_addr == 5'd0) ? 64'h0 :
                     (wr_fire && (rdest3 == rs2_addr)) ? WB_data1 : regs[rs2_addr];
  assign a0_bypass = (wr_fire && (rdest3 == 5'd10)) ? WB_data1 : regs[10];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 64'h0;
    end else if (wr_fire) begin
      regs[rdest3] <= WB_data1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (accept && is_ebreak) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   halt_code <= 64'h0;
    else if (accept && is_ebreak) halt_code <= a0_bypass;
  end

`ifdef YSYX_22041071_COMMIT_TRACE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_valid <= 1'b0;
      commit_pc    <= 64'h0;
      commit_ins   <= 32'h0;
      commit_wen   <= 1'b0;
      commit_wdest <= 5'd0;
      commit_wdata <= 64'h0;
      instr_cnt    <= 64'h0;
      cycle_cnt    <= 64'h0;
    end else begin
      commit_valid <= accept;
      if (accept) begin
        commit_pc    <= PC6;
        commit_ins   <= Ins5;
        commit_wen   <= wr_fire;
        commit_wdest <= rdest3;
        commit_wdata <= WB_data1;
        instr_cnt    <= instr_cnt + 64'd1;
      end
      if (state == RUN) cycle_cnt <= cycle_cnt + 64'd1;
    end
  end
`else
  logic unused_trace;
  assign unused_trace = ^PC6;
  assign commit_valid = 1'b0;
  assign commit_pc    = 64'h0;
  assign commit_ins   = 32'h0;
  assign commit_wen   = 1'b0;
  assign commit_wdest = 5'd0;
  assign commit_wdata = 64'h0;
  assign instr_cnt    = 64'h0;
  assign cycle_cnt    = 64'h0;
`endif

endmodule
`default_nettype wire
